// File: rtl/score_plotter.sv
// Paints the latched two-digit glyph map onto the VGA plot port, one pixel per
// clock, writing every cell as foreground or background so a redraw erases the last score.
module score_plotter #(
  parameter logic [7:0]  X0        = 8'd8,
  parameter logic [6:0]  Y0        = 7'd4,
  parameter int unsigned SCALE     = 2,
  parameter logic [2:0]  FG_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [29:0] map,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  localparam logic [1:0] SMAX = 2'(SCALE - 1);

  state_t      state, state_n;
  logic [29:0] snap, snap_n;
  logic        digit, digit_n;
  logic [2:0]  row, row_n;
  logic [1:0]  col, col_n, sx, sx_n, sy, sy_n;
  logic [7:0]  x_n;
  logic [6:0]  y_n;
  logic [2:0]  colour_n;
  logic        plot_n, busy_n, done_n;

  logic [7:0]  px;
  logic [6:0]  py;
  logic [4:0]  bit_idx;
  logic        sx_last, col_last, sy_last, row_last;

  // Sums are formed directly at output width; this equals 9-bit arithmetic truncated.
  always_comb begin
    px       = X0 + (digit ? 8'(4 * SCALE) : 8'd0) + 8'(col) * 8'(SCALE) + 8'(sx);
    py       = Y0 + 7'(row) * 7'(SCALE) + 7'(sy);
    bit_idx  = (digit ? 5'd0 : 5'd15) + 5'(row) * 5'd3 + 5'(col);
    sx_last  = (sx == SMAX);
    col_last = (col == 2'd2);
    sy_last  = (sy == SMAX);
    row_last = (row == 3'd4);
  end

  always_comb begin
    state_n  = state;
    snap_n   = snap;
    digit_n  = digit;
    row_n    = row;
    col_n    = col;
    sx_n     = sx;
    sy_n     = sy;
    x_n      = x;
    y_n      = y;
    colour_n = colour;
    plot_n   = 1'b0;
    busy_n   = busy;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = DRAW;
          snap_n  = map;
          digit_n = 1'b0;
          row_n   = '0;
          col_n   = '0;
          sx_n    = '0;
          sy_n    = '0;
          busy_n  = 1'b1;
        end
      end
      DRAW: begin
        plot_n   = 1'b1;
        x_n      = px;
        y_n      = py;
        colour_n = snap[bit_idx] ? FG_COLOUR : BG_COLOUR;
        // Odometer advance: sx, col, sy, row, digit; wrapping the digit ends the frame.
        if (!sx_last) begin
          sx_n = sx + 2'd1;
        end else begin
          sx_n = '0;
          if (!col_last) begin
            col_n = col + 2'd1;
          end else begin
            col_n = '0;
            if (!sy_last) begin
              sy_n = sy + 2'd1;
            end else begin
              sy_n = '0;
              if (!row_last) begin
                row_n = row + 3'd1;
              end else begin
                row_n = '0;
                if (!digit) begin
                  digit_n = 1'b1;
                end else begin
                  digit_n = 1'b0;
                  state_n = DONE;
                end
              end
            end
          end
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      snap   <= '0;
      digit  <= 1'b0;
      row    <= '0;
      col    <= '0;
      sx     <= '0;
      sy     <= '0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      snap   <= snap_n;
      digit  <= digit_n;
      row    <= row_n;
      col    <= col_n;
      sx     <= sx_n;
      sy     <= sy_n;
      x      <= x_n;
      y      <= y_n;
      colour <= colour_n;
      plot   <= plot_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_score_plotter.sv
// Bench for score_plotter: two instances (SCALE 1 and 2) checked against a
// pixel-order model through an expected-pixel queue.
module tb_score_plotter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic [29:0] map = '0;
  logic [7:0]  x1, x2;
  logic [6:0]  y1, y2;
  logic [2:0]  c1, c2;
  logic        p1, p2, b1, b2, d1, d2;

  localparam logic [29:0] MAP01 = {15'b111101101101111, 15'b100100100100100};

  int checks = 0;
  int failures = 0;
  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];

  always #5 clk = ~clk;

  score_plotter #(.X0(8'd10), .Y0(7'd5), .SCALE(1), .FG_COLOUR(3'b111), .BG_COLOUR(3'b000)) dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .map(map),
    .x(x1), .y(y1), .colour(c1), .plot(p1), .busy(b1), .done(d1));

  score_plotter #(.X0(8'd10), .Y0(7'd5), .SCALE(2), .FG_COLOUR(3'b111), .BG_COLOUR(3'b000)) dut2 (
    .clk(clk), .resetn(resetn), .start(start2), .map(map),
    .x(x2), .y(y2), .colour(c2), .plot(p2), .busy(b2), .done(d2));

  // Expected pixel k of a frame, decomposed from the scan order.
  function automatic logic [17:0] pix(input logic [29:0] m, input int s, input int k);
    int t, sx, col, sy, row, dig, idx, xv, yv;
    logic [7:0] xo;
    logic [6:0] yo;
    t = k;
    sx = t % s;  t = t / s;
    col = t % 3; t = t / 3;
    sy = t % s;  t = t / s;
    row = t % 5; dig = t / 5;
    xv = 10 + dig * 4 * s + col * s + sx;
    yv = 5 + row * s + sy;
    idx = (dig == 0 ? 15 : 0) + 3 * row + col;
    xo = 8'(xv);
    yo = 7'(yv);
    return {xo, yo, (m[idx] ? 3'b111 : 3'b000)};
  endfunction

  task automatic push_frame(input logic [29:0] m, input int s);
    exp_q.delete();
    for (int k = 0; k < 30 * s * s; k++) exp_q.push_back(pix(m, s, k));
  endtask

  // Raises start for one edge (E0); returns at the negedge after E0.
  task automatic kick(input int sel);
    @(negedge clk);
    if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Records pixels of one instance until a few cycles past done (bounded).
  // act: 0 none, 1 zero the map, 2 pulse start, applied after plot number act_at.
  task automatic capture(input int sel, input int act_at, input int act,
                         output int nplots, output int ndone, output int gap, output int bad);
    int last_plot, done_at, post;
    logic pl, bs, dn;
    nplots = 0; ndone = 0; bad = 0;
    last_plot = -1; done_at = -1; post = 0;
    got_q.delete();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      start1 = 1'b0;
      start2 = 1'b0;
      pl = (sel == 1) ? p1 : p2;
      bs = (sel == 1) ? b1 : b2;
      dn = (sel == 1) ? d1 : d2;
      if (pl && !bs) bad++;
      if (pl) begin
        got_q.push_back((sel == 1) ? {x1, y1, c1} : {x2, y2, c2});
        nplots++;
        last_plot = cyc;
        if (nplots == act_at && act == 1) map = '0;
        if (nplots == act_at && act == 2) begin
          if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
        end
      end
      if (dn) begin
        ndone++;
        if (done_at < 0) done_at = cyc;
      end
      if (done_at >= 0) begin
        post++;
        if (post > 4) break;
      end
    end
    gap = (done_at < 0) ? -1 : done_at - last_plot;
  endtask

  task automatic test_reset;
    int bad;
    bad = 0;
    resetn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start1 = i[0];
      start2 = i[0];
      if ({x1, y1, c1, p1, b1, d1, x2, y2, c2, p2, b2, d2} !== '0) bad++;
    end
    start1 = 1'b0;
    start2 = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_hold: nonzero output cycles=%0d required=0", bad);
    end
    @(negedge clk);
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if ({x1, y1, c1, p1, b1, d1, x2, y2, c2, p2, b2, d2} !== '0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_release: nonzero output cycles=%0d required=0", bad);
    end
  endtask

  task automatic test_scale1;
    int n, nd, gap, bad;
    logic [17:0] e, g;
    map = MAP01;
    push_frame(MAP01, 1);
    kick(1);
    checks++;
    if ({b1, p1} !== 2'b10) begin
      failures++;
      $display("FAIL s1_after_e0: busy,plot=%b required=10", {b1, p1});
    end
    capture(1, 0, 0, n, nd, gap, bad);
    checks++;
    if (n !== 30) begin failures++; $display("FAIL s1_plots: got=%0d required=30", n); end
    checks++;
    if (nd !== 1 || gap !== 1) begin
      failures++;
      $display("FAIL s1_done: count=%0d gap=%0d required 1,1", nd, gap);
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL s1_plot_wo_busy: got=%0d required=0", bad); end
    if (got_q.size() >= 18) begin
      checks++;
      if (got_q[0] !== {8'd10, 7'd5, 3'd7}) begin
        failures++; $display("FAIL s1_pix0: got=%h required=%h", got_q[0], {8'd10, 7'd5, 3'd7});
      end
      checks++;
      if (got_q[4] !== {8'd11, 7'd6, 3'd0}) begin
        failures++; $display("FAIL s1_pix4: got=%h required=%h", got_q[4], {8'd11, 7'd6, 3'd0});
      end
      checks++;
      if (got_q[15] !== {8'd14, 7'd5, 3'd0}) begin
        failures++; $display("FAIL s1_pix15: got=%h required=%h", got_q[15], {8'd14, 7'd5, 3'd0});
      end
      checks++;
      if (got_q[17] !== {8'd16, 7'd5, 3'd7}) begin
        failures++; $display("FAIL s1_pix17: got=%h required=%h", got_q[17], {8'd16, 7'd5, 3'd7});
      end
    end
    for (int k = 0; exp_q.size() > 0 && got_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL s1_pixel k=%0d: got=%h required=%h", k, g, e); end
    end
  endtask

  task automatic test_scale2;
    int n, nd, gap, bad;
    logic [17:0] e, g;
    map = MAP01;
    push_frame(MAP01, 2);
    kick(2);
    capture(2, 0, 0, n, nd, gap, bad);
    checks++;
    if (n !== 120 || nd !== 1 || gap !== 1 || bad !== 0) begin
      failures++;
      $display("FAIL s2_frame: plots=%0d done=%0d gap=%0d bad=%0d required 120,1,1,0", n, nd, gap, bad);
    end
    if (got_q.size() >= 61) begin
      checks++;
      if ({got_q[0], got_q[1], got_q[6], got_q[7]} !==
          {8'd10, 7'd5, 3'd7, 8'd11, 7'd5, 3'd7, 8'd10, 7'd6, 3'd7, 8'd11, 7'd6, 3'd7}) begin
        failures++;
        $display("FAIL s2_block: got=%h %h %h %h", got_q[0], got_q[1], got_q[6], got_q[7]);
      end
      checks++;
      if (got_q[60] !== {8'd18, 7'd5, 3'd0}) begin
        failures++; $display("FAIL s2_units0: got=%h required=%h", got_q[60], {8'd18, 7'd5, 3'd0});
      end
    end
    for (int k = 0; exp_q.size() > 0 && got_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL s2_pixel k=%0d: got=%h required=%h", k, g, e); end
    end
  endtask

  task automatic test_map_latch;
    int n, nd, gap, bad, errs;
    logic [17:0] e, g;
    map = MAP01;
    push_frame(MAP01, 1);
    kick(1);
    capture(1, 5, 1, n, nd, gap, bad);
    errs = 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      if (g !== e) errs++;
    end
    checks++;
    if (errs !== 0 || n !== 30) begin
      failures++; $display("FAIL map_latched: bad_pixels=%0d plots=%0d required 0,30", errs, n);
    end
    push_frame('0, 1);
    kick(1);
    capture(1, 0, 0, n, nd, gap, bad);
    errs = 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      if (g !== e) errs++;
    end
    checks++;
    if (errs !== 0 || n !== 30) begin
      failures++; $display("FAIL map_all_bg: bad_pixels=%0d plots=%0d required 0,30", errs, n);
    end
    map = MAP01;
  endtask

  task automatic test_start_ignored;
    int n, nd, gap, bad, errs;
    logic [17:0] e, g;
    map = MAP01;
    push_frame(MAP01, 1);
    kick(1);
    capture(1, 10, 2, n, nd, gap, bad);
    errs = 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      if (g !== e) errs++;
    end
    checks++;
    if (n !== 30 || nd !== 1 || errs !== 0) begin
      failures++;
      $display("FAIL start_ignored: plots=%0d done=%0d bad_pixels=%0d required 30,1,0", n, nd, errs);
    end
    checks++;
    if ({b1, p1} !== 2'b00) begin
      failures++; $display("FAIL start_not_queued: busy,plot=%b required=00", {b1, p1});
    end
  endtask

  task automatic test_reset_mid;
    int n, nd, gap, bad, cnt;
    logic [17:0] e, g;
    map = MAP01;
    kick(1);
    cnt = 0;
    for (int i = 0; i < 100 && cnt < 12; i++) begin
      @(negedge clk);
      if (p1) cnt++;
    end
    checks++;
    if (cnt !== 12) begin failures++; $display("FAIL mid_reach12: plots=%0d required=12", cnt); end
    resetn = 1'b0;
    #1;
    checks++;
    if ({p1, b1, d1, x1, y1, c1} !== '0) begin
      failures++;
      $display("FAIL mid_async_reset: plot=%b busy=%b x=%0d y=%0d required all 0", p1, b1, x1, y1);
    end
    @(negedge clk);
    resetn = 1'b1;
    push_frame(MAP01, 1);
    kick(1);
    capture(1, 0, 0, n, nd, gap, bad);
    checks++;
    if (got_q.size() == 0 || got_q[0] !== {8'd10, 7'd5, 3'd7}) begin
      failures++; $display("FAIL mid_restart_pix0: count=%0d required pixel (10,5) first", got_q.size());
    end
    for (int k = 0; exp_q.size() > 0 && got_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL mid_pixel k=%0d: got=%h required=%h", k, g, e); end
    end
    checks++;
    if (n !== 30) begin failures++; $display("FAIL mid_plots: got=%0d required=30", n); end
  endtask

  task automatic test_back_to_back;
    int first, second;
    first = -1;
    second = -1;
    @(negedge clk);
    start1 = 1'b1;
    for (int cyc = 0; cyc < 200 && second < 0; cyc++) begin
      @(negedge clk);
      if (d1) begin
        if (first < 0) first = cyc; else second = cyc;
      end
    end
    start1 = 1'b0;
    checks++;
    if (first < 0 || second - first !== 32) begin
      failures++; $display("FAIL back_to_back_period: got=%0d required=32", second - first);
    end
    repeat (40) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_scale1;
    test_scale2;
    test_map_latch;
    test_start_ignored;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
